// File: rtl/sat_dl_writer_if.sv
// Bundle of the HPS download stream and SDRAM write-port signals used by
// sat_dl_writer. The slave modport is the writer itself; the master modport
// is the environment (HPS side plus SDRAM port).
interface sat_dl_writer_if #(
  parameter int AW = 24
);
  logic          dl_active;
  logic          dl_wr;
  logic [24:0]   dl_addr;
  logic [15:0]   dl_data;
  logic          dl_wait;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_wr;
  logic          mem_busy;
  logic [AW-1:0] word_cnt;
  logic          ovf;
  logic          done;

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data, mem_busy,
    output dl_wait, mem_addr, mem_data, mem_wr, word_cnt, ovf, done
  );

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data, mem_busy,
    input  dl_wait, mem_addr, mem_data, mem_wr, word_cnt, ovf, done
  );
endinterface

// File: rtl/sat_dl_writer.sv
// Download write-buffer: byte-swaps 16-bit HPS download words, queues them
// with their SDRAM word addresses in a small FIFO, and issues them to the
// SDRAM write port through a level/busy handshake. Throttles the HPS with
// DL_WAIT and pulses DONE once a finished download has fully drained.
module sat_dl_writer #(
  parameter int AW    = 24,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sat_dl_writer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 16;

  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] WAIT_C   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] EMPTY_C  = {CW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE_C = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // HPS delivers words with bytes in the opposite order to the SDRAM port.
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  state_t        state_q, state_d;
  logic [EW-1:0] fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          active_q;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_data_q, mem_data_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          pending_q, pending_d;
  logic          dl_wait_q, dl_wait_d;

  logic          rise_s, fall_s, strobe_s;
  logic          full_s, empty_s;
  logic          push_s, drop_s, pop_s;
  logic          word_inc_s;
  logic          done_fire_s;
  logic [EW-1:0] head_s;
  logic [EW-1:0] entry_s;
  logic          unused_addr_s;

  assign rise_s   = bus.dl_active & ~active_q;
  assign fall_s   = ~bus.dl_active & active_q;
  assign strobe_s = bus.dl_wr & bus.dl_active;
  assign full_s   = (count_q == FULL_C);
  assign empty_s  = (count_q == EMPTY_C);
  assign push_s   = strobe_s & ~full_s;
  assign drop_s   = strobe_s & full_s;
  assign pop_s    = (state_q == ST_IDLE) & ~empty_s & ~bus.mem_busy;
  assign head_s   = fifo_q[rd_ptr_q];
  assign entry_s  = {bus.dl_addr[AW:1], byte_swap(bus.dl_data)};
  // Byte address bit 0 carries no information for 16-bit words.
  assign unused_addr_s = bus.dl_addr[0];

  // FIFO pointers, occupancy and the registered HPS throttle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d   = count_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    // One entry of margin absorbs a strobe the HPS already has in flight.
    dl_wait_d = (count_d >= WAIT_C);
  end

  // Write FSM: pop into the output registers, hold until the port accepts,
  // then wait out the busy period.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wr_d   = mem_wr_q;
    word_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          mem_addr_d = head_s[EW-1:16];
          mem_data_d = head_s[15:0];
          mem_wr_d   = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_busy) begin
          mem_wr_d   = 1'b0;
          word_inc_s = 1'b1;
          state_d    = ST_BUSY;
        end else begin
          state_d    = ST_ISSUE;
        end
      end
      ST_BUSY: begin
        if (!bus.mem_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        mem_wr_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Per-download bookkeeping: word count, overflow flag and completion.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    ovf_d       = ovf_q;
    pending_d   = pending_q;
    // A restart in the same cycle abandons the completion of the old download.
    done_fire_s = pending_q & ~rise_s & empty_s & (state_q == ST_IDLE);
    done_d      = done_fire_s;

    if (rise_s) begin
      word_cnt_d = {AW{1'b0}};
    end else begin
      word_cnt_d = word_cnt_q;
    end
    word_cnt_d = word_cnt_d + {{(AW-1){1'b0}}, word_inc_s};

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (rise_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (rise_s) begin
      pending_d = 1'b0;
    end else if (fall_s) begin
      pending_d = 1'b1;
    end else if (done_fire_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // FIFO storage; contents are discarded on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= entry_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      active_q   <= 1'b0;
      mem_addr_q <= {AW{1'b0}};
      mem_data_q <= 16'h0000;
      mem_wr_q   <= 1'b0;
      word_cnt_q <= {AW{1'b0}};
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
      dl_wait_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      active_q   <= bus.dl_active;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wr_q   <= mem_wr_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      dl_wait_q  <= dl_wait_d;
    end
  end

  assign bus.dl_wait  = dl_wait_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.word_cnt = word_cnt_q;
  assign bus.ovf      = ovf_q;
  assign bus.done     = done_q;

endmodule
